prbs16_checker: RTL

Serial pseudo-random sequence checker: the receive end of the 16-bit XNOR LFSR data generator (taps 15,14,12,3; feedback shifted into bit 0). It self-synchronises to an incoming one-bit-per-valid stream, declares lock, and then counts bit errors against its own free-running prediction. It sits downstream of any link or loopback that carries the generator's bit 0, and its counters feed the display path.

---
 rtl/prbs_pkg.sv | 32 +++
 rtl/prbs16_next.sv | 18 +
 rtl/prbs16_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the 16-bit XNOR PRBS generator/checker pair.
//   LFSR_W              : history / generator register width
//   TAP_A..TAP_D        : feedback tap positions (15, 14, 12, 3)
//   LOCKUP              : XNOR lockup pattern; the register never leaves it
//   state_t             : checker state (SEARCH, LOCKED)
//   shift_in()          : shift one bit into bit 0 of a history word
// -----------------------------------------------------------------------------
package prbs_pkg;

   localparam int LFSR_W = 16;

   localparam int TAP_A = 15;
   localparam int TAP_B = 14;
   localparam int TAP_C = 12;
   localparam int TAP_D = 3;

   localparam logic [LFSR_W-1:0] LOCKUP = 16'hFFFF;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Oldest bit leaves through the top, new bit enters at bit 0.
   function automatic logic [LFSR_W-1:0] shift_in(input logic [LFSR_W-1:0] h,
                                                  input logic              x);
      return {h[LFSR_W-2:0], x};
   endfunction

endpackage

// File: rtl/prbs16_next.sv
// -----------------------------------------------------------------------------
// prbs16_next
// Combinational XNOR feedback of the 16-bit PRBS polynomial. Both the
// generator and the checker instantiate this so the polynomial lives in one
// place.
//   i_state : current 16-bit register / history contents
//   o_bit   : next bit to be shifted into bit 0
// -----------------------------------------------------------------------------
module prbs16_next
   import prbs_pkg::*;
(
   input  logic [LFSR_W-1:0] i_state,
   output logic              o_bit
);

   assign o_bit = ~(i_state[TAP_A] ^ i_state[TAP_B] ^ i_state[TAP_C] ^ i_state[TAP_D]);

endmodule

// File: rtl/prbs16_checker.sv
// -----------------------------------------------------------------------------
// prbs16_checker
// Receive-side checker for the 16-bit XNOR PRBS stream. Self-synchronises by
// loading received bits into its history, declares lock after LOCK_COUNT
// consecutive correct predictions, then free-runs its own prediction and
// counts mismatches. LOSS_COUNT consecutive mismatches drop it back to search.
//
// Parameters
//   LOCK_COUNT : consecutive correct predictions needed for lock (>=1)
//   LOSS_COUNT : consecutive mispredictions that drop lock (>=1)
//   CNT_W      : width of err_count / bit_count
// Ports
//   clk        : clock, all logic on rising edge
//   reset      : synchronous active-high reset
//   din        : received sequence bit
//   din_valid  : din is meaningful this cycle; nothing advances otherwise
//   clr_counts : synchronous clear of both counters (beats any increment)
//   locked     : checker is in LOCKED
//   err_pulse  : one-cycle pulse per mispredicted bit while locked
//   err_count  : saturating count of mispredicted bits
//   bit_count  : saturating count of bits checked while locked
// -----------------------------------------------------------------------------
module prbs16_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_COUNT = 32,
   parameter int LOSS_COUNT = 8,
   parameter int CNT_W      = 16
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clr_counts,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam int FILL_W  = $clog2(LFSR_W + 1);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int BAD_W   = $clog2(LOSS_COUNT + 1);

   // Counters stick at all-ones rather than wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t              r_state;
   logic [LFSR_W-1:0]   r_h;
   logic [FILL_W-1:0]   r_fill;
   logic [MATCH_W-1:0]  r_match;
   logic [BAD_W-1:0]    r_bad_run;
   logic                r_locked;
   logic                r_err_pulse;
   logic [CNT_W-1:0]    r_err_count;
   logic [CNT_W-1:0]    r_bit_count;

   logic                w_pred;
   logic                w_miss;
   logic [LFSR_W-1:0]   w_h_search;
   logic [LFSR_W-1:0]   w_h_locked;
   logic [MATCH_W-1:0]  w_match_inc;
   logic [BAD_W-1:0]    w_bad_inc;

   prbs16_next u_next (
      .i_state (r_h),
      .o_bit   (w_pred)
   );

   assign w_miss      = (din != w_pred);
   // While searching the history follows the line; once locked it follows
   // the prediction so a single flipped bit costs exactly one error.
   assign w_h_search  = shift_in(r_h, din);
   assign w_h_locked  = shift_in(r_h, w_pred);
   assign w_match_inc = r_match + MATCH_W'(1);
   assign w_bad_inc   = r_bad_run + BAD_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= SEARCH;
         r_h         <= '0;
         r_fill      <= '0;
         r_match     <= '0;
         r_bad_run   <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_count <= '0;
         r_bit_count <= '0;
      end else begin
         r_err_pulse <= 1'b0;

         if (din_valid) begin
            case (r_state)
               SEARCH: begin
                  r_h <= w_h_search;
                  if (r_fill != FILL_W'(LFSR_W)) begin
                     // History not yet full of received bits: no prediction.
                     r_fill <= r_fill + FILL_W'(1);
                  end else if (w_miss) begin
                     r_match <= '0;
                  end else if (w_match_inc != MATCH_W'(LOCK_COUNT)) begin
                     r_match <= w_match_inc;
                  end else begin
                     r_match <= '0;
                     // An all-ones history predicts all-ones forever, so a
                     // stuck-high line must not be mistaken for the sequence.
                     if (w_h_search != LOCKUP) begin
                        r_state     <= LOCKED;
                        r_locked    <= 1'b1;
                        r_err_count <= '0;
                        r_bit_count <= '0;
                        r_bad_run   <= '0;
                     end
                  end
               end

               LOCKED: begin
                  r_h         <= w_h_locked;
                  r_bit_count <= sat_inc(r_bit_count);
                  if (w_miss) begin
                     r_err_pulse <= 1'b1;
                     r_err_count <= sat_inc(r_err_count);
                     if (w_bad_inc == BAD_W'(LOSS_COUNT)) begin
                        r_state   <= SEARCH;
                        r_locked  <= 1'b0;
                        r_fill    <= '0;
                        r_match   <= '0;
                        r_bad_run <= '0;
                     end else begin
                        r_bad_run <= w_bad_inc;
                     end
                  end else begin
                     r_bad_run <= '0;
                  end
               end

               default: begin
                  r_state  <= SEARCH;
                  r_locked <= 1'b0;
               end
            endcase
         end

         // Placed last so it overrides any increment or lock-entry clear.
         if (clr_counts) begin
            r_err_count <= '0;
            r_bit_count <= '0;
         end
      end
   end

   assign locked    = r_locked;
   assign err_pulse = r_err_pulse;
   assign err_count = r_err_count;
   assign bit_count = r_bit_count;

endmodule
